// File: rtl/maze_matrix_scanner.sv
// rtl/maze_matrix_scanner.sv - row-scan driver for the dual-colour maze LED matrix
//
// Fetches one row of map cells over a req/gnt memory port, decodes each cell
// into red/green column bits, then holds that row lit for ROW_HOLD cycles.
//
// Ports:
//   clk        system clock, rising edge
//   nst        synchronous reset, active high
//   blink_en   goal cells (code 3) blink when set
//   mem_req    map memory read request
//   mem_gnt    arbiter grant; address accepted when mem_req & mem_gnt
//   mem_addr   cell address = row*COLS + col
//   mem_rdata  cell data, valid the cycle after an accepted address
//   led_row    row select, active low (all ones = blank)
//   led_r_col  red column drive, active high
//   led_g_col  green column drive, active high
//   frame_done one-cycle pulse when the last row's hold ends

module maze_matrix_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DATA_W       = 2,
  parameter int ROW_HOLD     = 1000,
  parameter int BLINK_FRAMES = 32,
  localparam int ADDR_W      = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              nst,
  input  logic              blink_en,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ROWS-1:0]   led_row,
  output logic [COLS-1:0]   led_r_col,
  output logic [COLS-1:0]   led_g_col,
  output logic              frame_done
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int HOLD_W  = $clog2(ROW_HOLD + 1);
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {FETCH, SHOW} state_t;

  state_t             state, state_nx;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   cap_col;
  logic               cap_vld;
  logic               issue_done;
  logic [COLS-1:0]    shadow_r, shadow_g;
  logic [COLS-1:0]    shadow_r_nx, shadow_g_nx;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;
  logic [1:0]         code;
  logic               goal_off;

  logic accept, col_last, row_last, last_cap, hold_last;

  // Only bits [1:0] of a cell carry meaning.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, mem_rdata};

  assign accept    = mem_req & mem_gnt;
  assign col_last  = (col == COL_W'(COLS - 1));
  assign row_last  = (row == ROW_W'(ROWS - 1));
  assign last_cap  = cap_vld && (cap_col == COL_W'(COLS - 1));
  assign hold_last = (hold_cnt == HOLD_W'(ROW_HOLD - 1));

  // Shadow buffer with the in-flight capture merged, so the final column is
  // visible in the same edge that lights the row.
  always_comb begin
    shadow_r_nx = shadow_r;
    shadow_g_nx = shadow_g;
    code        = mem_rdata[1:0];
    goal_off    = blink_en & blink_phase;
    if (cap_vld) begin
      shadow_r_nx[cap_col] = (code == 2'd1) || ((code == 2'd3) && !goal_off);
      shadow_g_nx[cap_col] = (code == 2'd2) || ((code == 2'd3) && !goal_off);
    end
  end

  always_ff @(posedge clk) begin
    if (nst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH: if (last_cap)  state_nx = SHOW;
      SHOW:  if (hold_last) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nst) begin
      row         <= '0;
      col         <= '0;
      cap_col     <= '0;
      cap_vld     <= 1'b0;
      issue_done  <= 1'b0;
      shadow_r    <= '0;
      shadow_g    <= '0;
      hold_cnt    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      led_row     <= '1;
      led_r_col   <= '0;
      led_g_col   <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cap_vld    <= accept;
      cap_col    <= col;
      shadow_r   <= shadow_r_nx;
      shadow_g   <= shadow_g_nx;
      case (state)
        FETCH: begin
          if (accept) begin
            if (col_last) begin
              // Address stays at the row's last cell; SHOW exit steps it on.
              mem_req    <= 1'b0;
              issue_done <= 1'b1;
            end else begin
              col      <= col + COL_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end else if (!issue_done) begin
            mem_req <= 1'b1;
          end
          if (last_cap) begin
            led_row   <= ~(ROWS'(1) << row);
            led_r_col <= shadow_r_nx;
            led_g_col <= shadow_g_nx;
            hold_cnt  <= '0;
          end
        end
        SHOW: begin
          if (hold_last) begin
            hold_cnt   <= '0;
            led_row    <= '1;
            led_r_col  <= '0;
            led_g_col  <= '0;
            col        <= '0;
            mem_req    <= 1'b1;
            issue_done <= 1'b0;
            if (row_last) begin
              row        <= '0;
              mem_addr   <= '0;
              frame_done <= 1'b1;
              if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
              end
            end else begin
              row      <= row + ROW_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_matrix_scanner.sv
// tb/tb_maze_matrix_scanner.sv - directed bench for maze_matrix_scanner (8x8 and 4x16 geometries)

module tb_maze_matrix_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 instance, 3-bit cells so the ignored upper bit is exercised
  logic        nst = 1'b1, blink_en = 1'b0, gnt_toggle = 1'b0;
  logic        mem_req, mem_gnt = 1'b1, frame_done;
  logic [5:0]  mem_addr;
  logic [2:0]  mem_rdata = '0;
  logic [7:0]  led_row, led_r_col, led_g_col;
  logic [2:0]  map [64];

  // 4x16 instance
  logic        nst2 = 1'b1, blink_en2 = 1'b1;
  logic        mem_req2, mem_gnt2 = 1'b1, frame_done2;
  logic [5:0]  mem_addr2;
  logic [1:0]  mem_rdata2 = '0;
  logic [3:0]  led_row2;
  logic [15:0] led_r_col2, led_g_col2;
  logic [1:0]  map2 [64];

  int checks = 0, errors = 0;
  int done_cnt = 0, done2_cnt = 0, max_addr2 = 0;

  maze_matrix_scanner #(.ROWS(8), .COLS(8), .DATA_W(3), .ROW_HOLD(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .nst(nst), .blink_en(blink_en), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .led_row(led_row), .led_r_col(led_r_col),
    .led_g_col(led_g_col), .frame_done(frame_done));

  maze_matrix_scanner #(.ROWS(4), .COLS(16), .DATA_W(2), .ROW_HOLD(3), .BLINK_FRAMES(1)) dut2 (
    .clk(clk), .nst(nst2), .blink_en(blink_en2), .mem_req(mem_req2), .mem_gnt(mem_gnt2),
    .mem_addr(mem_addr2), .mem_rdata(mem_rdata2), .led_row(led_row2), .led_r_col(led_r_col2),
    .led_g_col(led_g_col2), .frame_done(frame_done2));

  // Memory/arbiter models: data one cycle after acceptance, junk otherwise.
  always @(posedge clk) begin
    mem_gnt    <= gnt_toggle ? ~mem_gnt : 1'b1;
    mem_rdata  <= (mem_req && mem_gnt) ? map[mem_addr] : 3'($urandom);
    mem_rdata2 <= (mem_req2 && mem_gnt2) ? map2[mem_addr2] : 2'($urandom);
  end

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_done2) done2_cnt++;
    if (mem_req2 && int'(mem_addr2) > max_addr2) max_addr2 = int'(mem_addr2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // Called at a negedge; returns the number of blank negedges seen before a lit row.
  task automatic wait_lit(input bit sel, output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sel ? (led_row2 != 4'hF) : (led_row != 8'hFF)) begin ok = 1'b1; break; end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_blank(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sel ? (led_row2 == 4'hF) : (led_row == 8'hFF)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    nst = 1'b1; blink_en = 1'b0; gnt_toggle = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (led_row !== 8'hFF) begin errors++; $display("FAIL reset_led_row got %h want ff", led_row); end
    checks++; if ({led_r_col, led_g_col} !== 16'h0) begin errors++; $display("FAIL reset_cols got %h/%h want 0", led_r_col, led_g_col); end
    checks++; if ({mem_req, frame_done} !== 2'b00) begin errors++; $display("FAIL reset_req_done got %b want 00", {mem_req, frame_done}); end
    checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    nst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL release_req got %b want 1", mem_req); end
    checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL release_addr got %0d want 0", mem_addr); end
  endtask

  task automatic test_row_decode;
    int n, h; bit ok;
    wait_lit(1'b0, n, ok);
    checks++; if (!ok || n != 9) begin errors++; $display("FAIL fetch_len got %0d (ok=%0b) want 9", n, ok); end
    checks++; if (led_row !== 8'hFE) begin errors++; $display("FAIL row0_sel got %h want fe", led_row); end
    checks++; if (led_r_col !== 8'hAA) begin errors++; $display("FAIL row0_red got %h want aa", led_r_col); end
    checks++; if (led_g_col !== 8'hCC) begin errors++; $display("FAIL row0_green got %h want cc", led_g_col); end
    gnt_toggle = 1'b1;
    h = 0;
    while (led_row == 8'hFE && h < 50) begin h++; @(negedge clk); end
    checks++; if (h != 4) begin errors++; $display("FAIL row_hold got %0d want 4", h); end
  endtask

  task automatic test_gnt_toggle;
    int exp_addr; bit ok;
    exp_addr = 8;
    for (int i = 0; i < 100; i++) begin
      if (led_row != 8'hFF) break;
      if (mem_req) begin
        checks++;
        if (mem_addr !== 6'(exp_addr)) begin errors++; $display("FAIL gnt_addr got %0d want %0d", mem_addr, exp_addr); end
        if (mem_gnt) exp_addr++;
      end
      @(negedge clk);
    end
    checks++; if (exp_addr != 16) begin errors++; $display("FAIL gnt_accepts got %0d want 16", exp_addr); end
    checks++; if (led_row !== 8'hFD) begin errors++; $display("FAIL row1_sel got %h want fd", led_row); end
    checks++; if ({led_r_col, led_g_col} !== 16'h00FF) begin errors++; $display("FAIL row1_cols got %h/%h want 00/ff", led_r_col, led_g_col); end
    gnt_toggle = 1'b0;
    wait_blank(1'b0, ok);
  endtask

  task automatic test_blink;
    int n; bit ok; logic [7:0] one, exp_row, exp_col;
    one = 8'd1;
    for (int a = 0; a < 64; a++) map[a] = (a % 5 == 0) ? 3'd7 : 3'd3;
    nst = 1'b1; blink_en = 1'b1;
    @(negedge clk);
    nst = 1'b0; done_cnt = 0;
    for (int f = 0; f < 5; f++) begin
      for (int r = 0; r < 8; r++) begin
        if (f == 4 && r > 0) break;
        wait_lit(1'b0, n, ok);
        exp_row = ~(one << r);
        exp_col = (f % 4 < 2) ? 8'hFF : 8'h00;
        checks++; if (!ok || led_row !== exp_row) begin errors++; $display("FAIL blink_row f%0d r%0d got %h want %h", f, r, led_row, exp_row); end
        checks++; if (led_r_col !== exp_col || led_g_col !== exp_col) begin errors++; $display("FAIL blink_cols f%0d r%0d got %h/%h want %h", f, r, led_r_col, led_g_col, exp_col); end
        if (r == 0) begin
          checks++; if (done_cnt != f) begin errors++; $display("FAIL frame_done_count f%0d got %0d want %0d", f, done_cnt, f); end
        end
        wait_blank(1'b0, ok);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n; bit ok, found;
    for (int a = 0; a < 64; a++) map[a] = (a / 8 == 5) ? 3'd1 : 3'd2;
    nst = 1'b1; blink_en = 1'b0;
    @(negedge clk);
    nst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mem_req && mem_addr == 6'd42) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach_row5 got 0 want 1"); end
    nst = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, led_row} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL mid_reset_state got %b/%h want 0/ff", mem_req, led_row); end
    nst = 1'b0;
    wait_lit(1'b0, n, ok);
    checks++; if (!ok || led_row !== 8'hFE) begin errors++; $display("FAIL mid_first_row got %h want fe", led_row); end
    checks++; if ({led_r_col, led_g_col} !== 16'h00FF) begin errors++; $display("FAIL mid_stale_cols got %h/%h want 00/ff", led_r_col, led_g_col); end
  endtask

  task automatic test_geometry;
    int n; bit ok; logic [3:0] one, exp_row; logic [15:0] exp_r, exp_g;
    one = 4'd1;
    for (int a = 0; a < 64; a++) map2[a] = 2'(a % 4);
    nst2 = 1'b0; done2_cnt = 0; max_addr2 = 0;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 4; r++) begin
        if (f == 2 && r > 0) break;
        wait_lit(1'b1, n, ok);
        exp_row = ~(one << r);
        exp_r = (f % 2 == 0) ? 16'hAAAA : 16'h2222;
        exp_g = (f % 2 == 0) ? 16'hCCCC : 16'h4444;
        checks++; if (!ok || led_row2 !== exp_row) begin errors++; $display("FAIL geo_row f%0d r%0d got %h want %h", f, r, led_row2, exp_row); end
        checks++; if (led_r_col2 !== exp_r || led_g_col2 !== exp_g) begin errors++; $display("FAIL geo_cols f%0d r%0d got %h/%h want %h/%h", f, r, led_r_col2, led_g_col2, exp_r, exp_g); end
        wait_blank(1'b1, ok);
      end
    end
    checks++; if (max_addr2 != 63) begin errors++; $display("FAIL geo_max_addr got %0d want 63", max_addr2); end
    checks++; if (done2_cnt != 2) begin errors++; $display("FAIL geo_frames got %0d want 2", done2_cnt); end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) map[a] = 3'd0;
    for (int c = 0; c < 8; c++) map[c] = 3'(c % 4) | ((c >= 4) ? 3'd4 : 3'd0);
    for (int c = 8; c < 16; c++) map[c] = (c % 2 == 0) ? 3'd6 : 3'd2;
    for (int a = 0; a < 64; a++) map2[a] = 2'd0;
    @(negedge clk);
    test_reset;
    test_row_decode;
    test_gnt_toggle;
    test_blink;
    test_reset_mid;
    test_geometry;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
